// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: write-back select,
// forwarding selects, memory-wait FSM states and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] WD_SEL_LOAD = 2'd1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // The younger producer (MEM) wins over WB; x0 is hard-wired zero and never forwards.
  function automatic logic [1:0] fwd_pick(
    input logic       mem_we,
    input logic [4:0] mem_wr,
    input logic       wb_we,
    input logic [4:0] wb_wr,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_wr != 5'd0) && (mem_wr == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_wr != 5'd0) && (wb_wr == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding compare: picks the operand source for both ALU inputs.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       mem_rf_we_i,
  input  logic [4:0] mem_rf_wr_i,
  input  logic       wb_rf_we_i,
  input  logic [4:0] wb_rf_wr_i,
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o
);

  always_comb begin
    fwd_a_sel_o = fwd_pick(mem_rf_we_i, mem_rf_wr_i, wb_rf_we_i, wb_rf_wr_i, ex_rs1_i);
    fwd_b_sel_o = fwd_pick(mem_rf_we_i, mem_rf_wr_i, wb_rf_we_i, wb_rf_wr_i, ex_rs2_i);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline, with a
// data-memory wait FSM (timeout to a sticky error) and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int         TIMEOUT = 64,          // must be >= 2
  parameter logic [1:0] WD_LOAD = WD_SEL_LOAD,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic             ex_rf_we_i,
  input  logic [4:0]       ex_rf_wr_i,
  input  logic [1:0]       ex_wd_sel_i,
  input  logic             mem_rf_we_i,
  input  logic [4:0]       mem_rf_wr_i,
  input  logic [1:0]       mem_wd_sel_i,
  input  logic             wb_rf_we_i,
  input  logic [4:0]       wb_rf_wr_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_err_o
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                timeout_err_q;

  logic                stall_all;
  logic                load_use;
  logic [1:0]          fwd_a_raw;
  logic [1:0]          fwd_b_raw;
  logic                mem_wd_is_load;

  // MEM-stage load flag is not needed for the current forwarding rules.
  assign mem_wd_is_load = (mem_wd_sel_i == WD_LOAD);

  assign stall_all = ((state_q == ST_IDLE) && mem_req_i && !dmem_ack_i) ||
                     ((state_q == ST_MEM_WAIT) && !dmem_ack_i) ||
                     (state_q == ST_ERR);

  assign load_use = ex_rf_we_i && (ex_wd_sel_i == WD_LOAD) && (ex_rf_wr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rf_wr_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rf_wr_i)));

  fwd_unit u_fwd (
    .mem_rf_we_i (mem_rf_we_i),
    .mem_rf_wr_i (mem_rf_wr_i),
    .wb_rf_we_i  (wb_rf_we_i),
    .wb_rf_wr_i  (wb_rf_wr_i),
    .ex_rs1_i    (ex_rs1_i),
    .ex_rs2_i    (ex_rs2_i),
    .fwd_a_sel_o (fwd_a_raw),
    .fwd_b_sel_o (fwd_b_raw)
  );

  // A redirect seen during a memory stall stays asserted because EX is frozen,
  // so it is naturally serviced in the release cycle.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_stall_o  = 1'b0;
    ex_mem_stall_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    fwd_a_sel_o    = FWD_RF;
    fwd_b_sel_o    = FWD_RF;
    if (!rst) begin
      fwd_a_sel_o = fwd_a_raw;
      fwd_b_sel_o = fwd_b_raw;
      if (stall_all) begin
        pc_stall_o     = 1'b1;
        if_id_stall_o  = 1'b1;
        id_ex_stall_o  = 1'b1;
        ex_mem_stall_o = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (ex_redirect_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req_i && !dmem_ack_i) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_q       <= ST_ERR;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_ERR: begin
          timeout_err_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign timeout_err_o = timeout_err_q;

  logic unused_ok;
  assign unused_ok = mem_wd_is_load;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB registers).
- Detects load-use hazards, EX-stage redirects and multi-cycle data-memory accesses.
- Drives per-register stall/flush enables and EX-stage forwarding selects.
- Holds a memory-wait FSM with timeout and a saturating stall-cycle counter.

Parameters:
- TIMEOUT, 64: max wait cycles for one dmem access before the error state; must be ≥2.
- WD_LOAD, 2'd1: wd_sel encoding that marks a load (write-back data from load_ext).
- CNT_W, 32: stall-counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- id_rs1_used, id_rs2_used  in  1 each  source actually read by the ID instruction
- ex_rs1, ex_rs2  in  5 each  EX-stage source registers
- ex_rf_we, ex_rf_wr, ex_wd_sel  in  1/5/2  EX destination info
- mem_rf_we, mem_rf_wr, mem_wd_sel  in  1/5/2  MEM destination info
- wb_rf_we, wb_rf_wr  in  1/5  WB destination info
- ex_redirect  in  1  branch/jump taken, resolved in EX
- mem_req  in  1  MEM-stage instruction accesses dmem
- dmem_ack  in  1  dmem completes the access this cycle
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold register
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble (all fields 0) next edge
- fwd_a_sel, fwd_b_sel  out  2 each  00 = RF, 01 = MEM, 10 = WB
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- timeout_err  out  1  sticky error

Behaviour:
- Reset (rst=1, async): state=IDLE, wait_cnt=0, stall_cnt=0, timeout_err=0. All stall/flush/fwd outputs are forced 0 while rst is high.
- FSM states are IDLE, MEM_WAIT and ERR. stall_all = (IDLE & mem_req & ~dmem_ack) | (MEM_WAIT & ~dmem_ack) | ERR.
- IDLE:
  - mem_req & ~dmem_ack → MEM_WAIT, wait_cnt=1.
  - mem_req & dmem_ack is a zero-wait access: no stall, stay IDLE.
- MEM_WAIT:
  - dmem_ack → IDLE, wait_cnt=0. The pipeline advances in the ack cycle.
  - ~dmem_ack & wait_cnt==TIMEOUT-1 → ERR.
  - Otherwise wait_cnt++.
- ERR: terminal until rst. timeout_err=1 and stall_all held.
- Output priority, highest first:
  1. stall_all: pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, other flushes 0. A redirect that arrives during a stall is not lost: EX is frozen, so ex_redirect stays asserted and is serviced in the release cycle.
  2. ex_redirect: if_id_flush=1, id_ex_flush=1, no stalls. Any load-use condition is ignored because the ID instruction is squashed.
  3. Load-use: pc_stall=1, if_id_stall=1, id_ex_flush=1. The condition is ex_rf_we & ex_wd_sel==WD_LOAD & ex_rf_wr!=0 & ((id_rs1_used & id_rs1==ex_rf_wr) | (id_rs2_used & id_rs2==ex_rf_wr)).
  4. Otherwise all stall/flush outputs are 0.
- Forwarding (combinational, independent of stall):
  - fwd_a_sel=01 if mem_rf_we & mem_rf_wr!=0 & mem_rf_wr==ex_rs1.
  - Else fwd_a_sel=10 if wb_rf_we & wb_rf_wr!=0 & wb_rf_wr==ex_rs1.
  - Else fwd_a_sel=00. fwd_b_sel is identical using ex_rs2.
  - MEM beats WB. Register x0 never forwards.
- stall_cnt increments on each clock edge where pc_stall=1 and saturates at all-ones.
- Asserting rst mid-wait returns to IDLE immediately. A pending access is abandoned; the dmem side is the owner's concern.

Decomposition:
- Shared package: WD_LOAD encoding, FWD_RF/FWD_MEM/FWD_WB constants, FSM state encoding (2-bit).
- One natural sub-module, fwd_unit: pure combinational forwarding compare, instantiated once. The FSM, counters and priority mux stay in the top.

Test Plan:
- Load-use: ex is a load to x5, id_rs1=5 with id_rs1_used=1 → one cycle of pc_stall=if_id_stall=id_ex_flush=1. The next cycle is clear; stall_cnt=1.
- Zero-wait access: mem_req=1, dmem_ack=1 in the same cycle → no stall, state stays IDLE.
- Three-cycle wait: mem_req=1, ack in the 3rd cycle → stall_all for 2 cycles with mem_wb_flush=1, release in the ack cycle, stall_cnt=2.
- Redirect during wait: ex_redirect=1 across a 2-cycle wait → flushes suppressed during the stall, then if_id_flush=id_ex_flush=1 in the ack cycle.
- Timeout with TIMEOUT=4: mem_req held, no ack → ERR after 4 cycles, timeout_err=1, stalls held. Asserting rst clears everything asynchronously.
- Forwarding: mem_rf_wr=wb_rf_wr=7, both we=1, ex_rs1=7 → fwd_a_sel=01. With mem_rf_wr=0 and ex_rs2=0 → fwd_b_sel=00.
